// File: rtl/pipeline_hazard_ctrl.sv
// Front-end hazard sequencer for the IF/ID/EX stages around decode.
// Resolves load-use stalls, taken-jump flushes and data-memory wait holds,
// and keeps a saturating count of cycles in which the PC was held.
module pipeline_hazard_ctrl #(
    parameter int unsigned ADDR_W       = 64,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_bypass,
    input  logic              jmp_taken,
    input  logic [ADDR_W-1:0] jmp_addr,
    input  logic              mem_busy,
    output logic              hold_pc,
    output logic              hold_if_id,
    output logic              hold_id_ex,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic              pc_redirect,
    output logic [ADDR_W-1:0] redirect_addr,
    output logic [1:0]        state_o,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int unsigned     FC_W      = $clog2(FLUSH_CYCLES + 1);
    localparam logic [FC_W-1:0] FC_RELOAD = FC_W'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LD_STALL = 2'd1,
        FLUSH    = 2'd2,
        MEM_WAIT = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [FC_W-1:0]    fcnt_q, fcnt_d;
    logic               pend_jmp_q, pend_jmp_d;
    logic [ADDR_W-1:0]  pend_addr_q, pend_addr_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    // Ungated control values; the ports are forced low while reset is asserted.
    logic               hold_pc_c, hold_if_id_c, hold_id_ex_c;
    logic               flush_if_id_c, flush_id_ex_c, pc_redirect_c;
    logic [ADDR_W-1:0]  redirect_addr_c;
    logic               do_redir;
    logic [ADDR_W-1:0]  redir_tgt;

    // Next-state and control decode; mem_busy > jump/pending jump > load_bypass.
    always_comb begin
        state_d         = state_q;
        fcnt_d          = fcnt_q;
        pend_jmp_d      = pend_jmp_q;
        pend_addr_d     = pend_addr_q;
        hold_pc_c       = 1'b0;
        hold_if_id_c    = 1'b0;
        hold_id_ex_c    = 1'b0;
        flush_if_id_c   = 1'b0;
        flush_id_ex_c   = 1'b0;
        pc_redirect_c   = 1'b0;
        redirect_addr_c = '0;
        do_redir        = 1'b0;
        redir_tgt       = jmp_addr;

        if (state_q == MEM_WAIT) begin
            if (mem_busy) begin
                hold_pc_c    = 1'b1;
                hold_if_id_c = 1'b1;
                hold_id_ex_c = 1'b1;
                if (jmp_taken) begin
                    pend_jmp_d  = 1'b1;
                    pend_addr_d = jmp_addr;
                end
            end else if (jmp_taken) begin
                // A jump in the exit cycle is younger than the pending one.
                do_redir = 1'b1;
            end else if (pend_jmp_q) begin
                do_redir  = 1'b1;
                redir_tgt = pend_addr_q;
            end else if (fcnt_q != '0) begin
                state_d = FLUSH;
            end else begin
                state_d = RUN;
            end
        end else if (mem_busy) begin
            // Flush count is left untouched so an interrupted FLUSH resumes.
            hold_pc_c    = 1'b1;
            hold_if_id_c = 1'b1;
            hold_id_ex_c = 1'b1;
            if (jmp_taken) begin
                pend_jmp_d  = 1'b1;
                pend_addr_d = jmp_addr;
            end
            state_d = MEM_WAIT;
        end else if (jmp_taken) begin
            do_redir = 1'b1;
        end else if (state_q == FLUSH) begin
            flush_if_id_c = 1'b1;
            if (fcnt_q <= FC_W'(1)) begin
                fcnt_d  = '0;
                state_d = RUN;
            end else begin
                fcnt_d = fcnt_q - FC_W'(1);
            end
        end else if (load_bypass && state_q == RUN) begin
            hold_pc_c     = 1'b1;
            hold_if_id_c  = 1'b1;
            flush_id_ex_c = 1'b1;
            state_d       = LD_STALL;
        end else begin
            state_d = RUN;
        end

        if (do_redir) begin
            pc_redirect_c   = 1'b1;
            redirect_addr_c = redir_tgt;
            flush_if_id_c   = 1'b1;
            flush_id_ex_c   = 1'b1;
            pend_jmp_d      = 1'b0;
            if (FLUSH_CYCLES <= 1) begin
                fcnt_d  = '0;
                state_d = RUN;
            end else begin
                fcnt_d  = FC_RELOAD;
                state_d = FLUSH;
            end
        end
    end

    // Saturating count of PC-hold cycles.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hold_pc_c && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // State, flush counter, pending jump and stall counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            fcnt_q      <= '0;
            pend_jmp_q  <= 1'b0;
            pend_addr_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            pend_jmp_q  <= pend_jmp_d;
            pend_addr_q <= pend_addr_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign hold_pc       = rst_n & hold_pc_c;
    assign hold_if_id    = rst_n & hold_if_id_c;
    assign hold_id_ex    = rst_n & hold_id_ex_c;
    assign flush_if_id   = rst_n & flush_if_id_c;
    assign flush_id_ex   = rst_n & flush_id_ex_c;
    assign pc_redirect   = rst_n & pc_redirect_c;
    assign redirect_addr = rst_n ? redirect_addr_c : '0;
    assign state_o       = state_q;
    assign stall_cnt     = stall_cnt_q;

endmodule
